ram_rr_arbiter: RTL
===================

Name: ram_rr_arbiter

Overview:
- Shares the 32-bit word RAM between two requesters: the wishbone slave (port 1) and the GPIO controller (port 2).
- The RAM is four 8-bit openRam byte banks, 32 words deep.
- Uses round-robin arbitration with a registered grant/response handshake, per-byte write enables and out-of-range address detection.
- Sits between wbSlave/gpioCtrl and the four openRam instances, replacing their direct connection.

Parameters:
- ADDR_W, 8, requester word-address width.
- RAM_AW, 5, RAM bank address width; depth is 2^RAM_AW words.
- DATA_W, 32, word width; fixed at 4 bytes.

Ports:
- CLK  in  1  system clock, rising edge.
- RSTb  in  1  reset: one clock; reset is asynchronous and active-low.
- REQ1/REQ2  in  1  request from port 1 / port 2.
- WE1/WE2  in  1  1=write, 0=read.
- BE1/BE2  in  4  byte enables (writes only).
- ADDR1/ADDR2  in  ADDR_W  word address.
- WDATA1/WDATA2  in  32  write data.
- GNT1/GNT2  out  1  one-cycle grant; the command has been accepted.
- RVALID1/RVALID2  out  1  one-cycle completion strobe, for reads and writes.
- RDATA1/RDATA2  out  32  read data, valid with RVALID.
- ERR1/ERR2  out  1  out-of-range flag, valid with RVALID.
- RAM_CSb  out  4  per-bank chip select, active-low.
- RAM_WEb  out  4  per-bank write enable, active-low.
- RAM_ADDR  out  RAM_AW  shared bank address.
- RAM_DATA_IN  out  32  bank write data; byte i goes to bank i.
- RAM_DATA_OUT  in  32  bank read data; valid the cycle after a CSb-low read cycle.

Behaviour:
- Reset values: GNTx=0, RVALIDx=0, ERRx=0, RDATAx=0, RAM_CSb=4'hF, RAM_WEb=4'hF, RAM_ADDR=0, RAM_DATA_IN=0, state=IDLE, rr pointer=port 2 (so port 1 wins the first tie).
- All outputs are registered.
- FSM states: IDLE, ACCESS, RESP.
- IDLE: if any REQ is sampled high, latch the winner's command and go to ACCESS; otherwise stay.
- ACCESS (one cycle):
  - GNTwinner=1.
  - RAM pins are driven from the latched command: RAM_ADDR=ADDR[RAM_AW-1:0], RAM_DATA_IN=WDATA.
  - Read: RAM_CSb=0000, RAM_WEb=1111.
  - Write: RAM_CSb[i]=~BE[i], RAM_WEb[i]=~BE[i].
  - Go to RESP.
- RESP (one cycle):
  - RAM_CSb/RAM_WEb return to 1111.
  - RDATAwinner is loaded from RAM_DATA_OUT on a read, unchanged on a write.
  - RVALIDwinner=1 in the following cycle.
  - Requests are re-arbitrated: any REQ high → ACCESS with the new winner; otherwise → IDLE.
- Latency: REQ sampled at edge k → GNT high in cycle k+1 → RVALID high in cycle k+3.
- Throughput: one transaction every 2 cycles under continuous load.
- Handshake:
  - The requester holds REQ, WE, BE, ADDR and WDATA stable until it sees GNT.
  - In the cycle after GNT it either deasserts REQ or presents its next command.
  - REQ is sampled only in IDLE and RESP; a REQ dropped before GNT is legal and withdraws the request.
- Arbitration:
  - Single requester: granted.
  - Both requesting: the port that did not win last is granted.
  - The rr pointer updates only on grant.
- Out of range: ADDR[ADDR_W-1:RAM_AW] != 0 → no RAM access (CSb stays 1111 in ACCESS); RVALID with ERR=1 and RDATA=0; writes are dropped.
- BE=0000 write: no bank enabled; RVALID still pulses, ERR=0.
- ERR is cleared on every in-range completion.
- RVALID and GNT never assert for both ports in the same cycle.
- Asynchronous reset mid-transaction: the in-flight command is discarded, there is no RVALID, all RAM control goes inactive immediately, and the rr pointer returns to its reset value.

Test Plan:
- Port 1 write ADDR=0x05, WDATA=0xDEADBEEF, BE=1111, then port 1 read 0x05 → GNT1 one cycle after REQ sampled; read RVALID1 3 cycles after REQ sampled, RDATA1=0xDEADBEEF, ERR1=0.
- Port 2 write ADDR=0x05, WDATA=0x11223344, BE=0101, then read → RDATA2=0xDE22BE44; RAM_CSb=1010 and RAM_WEb=1010 in the write ACCESS cycle.
- REQ1 and REQ2 held high continuously for 8 transactions → grants alternate 1,2,1,2,…, starting with port 1 after reset; GNT spacing is 2 cycles.
- Port 2 read ADDR=0x20 → RAM_CSb stays 1111 throughout; RVALID2=1, ERR2=1, RDATA2=0. A following read of 0x1F gives ERR2=0.
- RSTb asserted low during ACCESS of a port 1 read → RAM_CSb=1111 and GNT1=0 asynchronously; no RVALID1 after release. The next simultaneous request grants port 1.
- Port 1 write with BE=0000 to 0x03 (pre-loaded 0xCAFEF00D) → RVALID1 pulses; a read of 0x03 returns 0xCAFEF00D.

Source files
------------

// File: rtl/ram_rr_arbiter_if.sv
// Bundles the two requester ports and the shared byte-bank RAM pins of ram_rr_arbiter.
// The master side is the surrounding system: requesters plus the RAM read-data return path.
interface ram_rr_arbiter_if #(
    parameter int ADDR_W = 8,
    parameter int RAM_AW = 5,
    parameter int DATA_W = 32
);
    logic                  req1;
    logic                  we1;
    logic [DATA_W/8-1:0]   be1;
    logic [ADDR_W-1:0]     addr1;
    logic [DATA_W-1:0]     wdata1;
    logic                  gnt1;
    logic                  rvalid1;
    logic [DATA_W-1:0]     rdata1;
    logic                  err1;

    logic                  req2;
    logic                  we2;
    logic [DATA_W/8-1:0]   be2;
    logic [ADDR_W-1:0]     addr2;
    logic [DATA_W-1:0]     wdata2;
    logic                  gnt2;
    logic                  rvalid2;
    logic [DATA_W-1:0]     rdata2;
    logic                  err2;

    logic [DATA_W/8-1:0]   ram_csb;
    logic [DATA_W/8-1:0]   ram_web;
    logic [RAM_AW-1:0]     ram_addr;
    logic [DATA_W-1:0]     ram_data_in;
    logic [DATA_W-1:0]     ram_data_out;

    modport master (
        output req1, we1, be1, addr1, wdata1,
        output req2, we2, be2, addr2, wdata2,
        output ram_data_out,
        input  gnt1, rvalid1, rdata1, err1,
        input  gnt2, rvalid2, rdata2, err2,
        input  ram_csb, ram_web, ram_addr, ram_data_in
    );

    modport slave (
        input  req1, we1, be1, addr1, wdata1,
        input  req2, we2, be2, addr2, wdata2,
        input  ram_data_out,
        output gnt1, rvalid1, rdata1, err1,
        output gnt2, rvalid2, rdata2, err2,
        output ram_csb, ram_web, ram_addr, ram_data_in
    );
endinterface

// File: rtl/ram_rr_arbiter.sv
// Round-robin arbiter sharing a four-bank byte-wide RAM between two word requesters.
// Every output is registered; a transaction runs IDLE/RESP -> ACCESS -> RESP.
module ram_rr_arbiter #(
    parameter int ADDR_W = 8,
    parameter int RAM_AW = 5,
    parameter int DATA_W = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    ram_rr_arbiter_if.slave bus
);
    localparam int NB = DATA_W / 8;

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t              state_q, state_d;
    logic                last_q, last_d;
    logic                cmd_port_q, cmd_port_d;
    logic                cmd_we_q, cmd_we_d;
    logic                cmd_oor_q, cmd_oor_d;
    logic                gnt1_q, gnt1_d, gnt2_q, gnt2_d;
    logic                rvalid1_q, rvalid1_d, rvalid2_q, rvalid2_d;
    logic [DATA_W-1:0]   rdata1_q, rdata1_d, rdata2_q, rdata2_d;
    logic                err1_q, err1_d, err2_q, err2_d;
    logic [NB-1:0]       csb_q, csb_d, web_q, web_d;
    logic [RAM_AW-1:0]   ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0]   ram_din_q, ram_din_d;

    logic                any_req;
    logic                pick2;
    logic                take;
    logic                sel_we;
    logic                sel_oor;
    logic [NB-1:0]       sel_be;
    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_wdata;

    // last_q = 1 means port 2 won most recently, so port 1 takes the next tie.
    assign any_req   = bus.req1 | bus.req2;
    assign pick2     = bus.req2 & (~bus.req1 | ~last_q);
    assign sel_we    = pick2 ? bus.we2    : bus.we1;
    assign sel_be    = pick2 ? bus.be2    : bus.be1;
    assign sel_addr  = pick2 ? bus.addr2  : bus.addr1;
    assign sel_wdata = pick2 ? bus.wdata2 : bus.wdata1;
    assign sel_oor   = |sel_addr[ADDR_W-1:RAM_AW];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            last_q     <= 1'b1;
            cmd_port_q <= 1'b0;
            cmd_we_q   <= 1'b0;
            cmd_oor_q  <= 1'b0;
            gnt1_q     <= 1'b0;
            gnt2_q     <= 1'b0;
            rvalid1_q  <= 1'b0;
            rvalid2_q  <= 1'b0;
            rdata1_q   <= '0;
            rdata2_q   <= '0;
            err1_q     <= 1'b0;
            err2_q     <= 1'b0;
            csb_q      <= '1;
            web_q      <= '1;
            ram_addr_q <= '0;
            ram_din_q  <= '0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            cmd_port_q <= cmd_port_d;
            cmd_we_q   <= cmd_we_d;
            cmd_oor_q  <= cmd_oor_d;
            gnt1_q     <= gnt1_d;
            gnt2_q     <= gnt2_d;
            rvalid1_q  <= rvalid1_d;
            rvalid2_q  <= rvalid2_d;
            rdata1_q   <= rdata1_d;
            rdata2_q   <= rdata2_d;
            err1_q     <= err1_d;
            err2_q     <= err2_d;
            csb_q      <= csb_d;
            web_q      <= web_d;
            ram_addr_q <= ram_addr_d;
            ram_din_q  <= ram_din_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        cmd_port_d = cmd_port_q;
        cmd_we_d   = cmd_we_q;
        cmd_oor_d  = cmd_oor_q;
        gnt1_d     = 1'b0;
        gnt2_d     = 1'b0;
        rvalid1_d  = 1'b0;
        rvalid2_d  = 1'b0;
        rdata1_d   = rdata1_q;
        rdata2_d   = rdata2_q;
        err1_d     = err1_q;
        err2_d     = err2_q;
        csb_d      = '1;
        web_d      = '1;
        ram_addr_d = ram_addr_q;
        ram_din_d  = ram_din_q;
        take       = 1'b0;

        case (state_q)
            IDLE: take = any_req;
            ACCESS: state_d = RESP;
            RESP: begin
                // RAM_DATA_OUT now carries the bank data captured during ACCESS.
                if (cmd_port_q) begin
                    rvalid2_d = 1'b1;
                    if (cmd_oor_q) begin
                        err2_d   = 1'b1;
                        rdata2_d = '0;
                    end else begin
                        err2_d = 1'b0;
                        if (!cmd_we_q) rdata2_d = bus.ram_data_out;
                    end
                end else begin
                    rvalid1_d = 1'b1;
                    if (cmd_oor_q) begin
                        err1_d   = 1'b1;
                        rdata1_d = '0;
                    end else begin
                        err1_d = 1'b0;
                        if (!cmd_we_q) rdata1_d = bus.ram_data_out;
                    end
                end
                take    = any_req;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (take) begin
            state_d    = ACCESS;
            last_d     = pick2;
            cmd_port_d = pick2;
            cmd_we_d   = sel_we;
            cmd_oor_d  = sel_oor;
            gnt1_d     = ~pick2;
            gnt2_d     = pick2;
            ram_addr_d = sel_addr[RAM_AW-1:0];
            ram_din_d  = sel_wdata;
            if (!sel_oor) begin
                csb_d = sel_we ? ~sel_be : '0;
                web_d = sel_we ? ~sel_be : '1;
            end
        end
    end

    assign bus.gnt1        = gnt1_q;
    assign bus.gnt2        = gnt2_q;
    assign bus.rvalid1     = rvalid1_q;
    assign bus.rvalid2     = rvalid2_q;
    assign bus.rdata1      = rdata1_q;
    assign bus.rdata2      = rdata2_q;
    assign bus.err1        = err1_q;
    assign bus.err2        = err2_q;
    assign bus.ram_csb     = csb_q;
    assign bus.ram_web     = web_q;
    assign bus.ram_addr    = ram_addr_q;
    assign bus.ram_data_in = ram_din_q;
endmodule
